obi_data_mem_responder: RTL and testbench
=========================================

Name: obi_data_mem_responder

Overview:
- Memory-side responder for the core's OBI data interface: grants data requests, performs byte-enabled writes and word reads on an internal array, and returns in-order read responses.
- Sits in the UVM top as the slave model attached to the core's data port.
- Enforces at most two outstanding transactions: granted but not yet answered with rvalid.

Parameters:
- ADDR_WIDTH, 32, width of data_addr_i.
- DATA_WIDTH, 32, data word width; byte-enable width is DATA_WIDTH/8.
- MEM_DEPTH, 1024, number of words in the array; must be a power of 2.
- MAX_OUTSTANDING, 2, response FIFO depth and outstanding limit.
- LFSR_SEED, 16'hACE1, reset seed for the stall LFSR (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- data_req_i  input  1  request from the core.
- data_gnt_o  output  1  grant; combinational from data_req_i and internal state.
- data_addr_i  input  ADDR_WIDTH  byte address.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  DATA_WIDTH/8  byte enables.
- data_wdata_i  input  DATA_WIDTH  write data.
- data_rvalid_o  output  1  response valid; one-cycle pulse per transaction.
- data_rdata_o  output  DATA_WIDTH  read data; valid only while data_rvalid_o is high.
- outstanding_o  output  2  granted-not-responded count, for coverage.

Behaviour:
- Reset (synchronous, active-high): FIFO count, pointers and outstanding count go to 0; data_rvalid_o=0; data_rdata_o=0; data_gnt_o=0 while rst is high; LFSR loads LFSR_SEED.
  - Memory contents are NOT cleared.
  - Reset mid-transaction discards all queued responses; no rvalid is issued for them.
- Word index = data_addr_i[log2(MEM_DEPTH)+1:2].
  - Addresses beyond the array wrap modulo MEM_DEPTH.
  - Bits [1:0] are ignored; data_be_i selects the bytes.
- Grant rule: data_gnt_o = data_req_i && (count < MAX_OUTSTANDING) && !gnt_stall.
  - gnt_stall is 0 unless the optional feature is enabled.
  - A pop in the same cycle does NOT free a slot for that cycle's grant; the decision uses the registered count only.
- Accepted transfer = data_req_i && data_gnt_o at a clk edge.
  - Write: bytes with data_be_i[k]=1 are updated at that edge. The queued response carries rdata=0.
  - Read: the word is sampled at that edge and pushed into the response FIFO, so read-after-write on back-to-back grants returns the new data.
  - Reads return the full word regardless of data_be_i.
- Response FIFO:
  - Depth MAX_OUTSTANDING; in order; one push and one pop allowed in the same cycle (count unchanged).
  - Pop occurs when count>0 && !rvalid_stall; the popped entry drives data_rvalid_o=1 and data_rdata_o registered for exactly that cycle.
  - Minimum latency is grant at edge N, rvalid high in cycle N+1; without stalls this latency is fixed at 1.
  - Back-to-back grants give back-to-back single-cycle rvalid pulses, with no rvalid gap.
- Boundary conditions:
  - FIFO full: gnt=0 regardless of req.
  - FIFO empty: rvalid=0.
  - outstanding_o = count of FIFO entries plus the entry presented on rvalid this cycle, saturating at MAX_OUTSTANDING. It never exceeds 2.
- Undefined inputs (X on addr/be while req is high) are not checked here; the protocol checker covers them.

Optional Feature:
- Macro: OBI_RESP_RAND_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle after reset.
  - gnt_stall = lfsr[0] && lfsr[3]; rvalid_stall = lfsr[5] && lfsr[9].
  - This gives ~25% grant and ~25% response backpressure, so the core sees 2-outstanding conditions and multi-cycle rvalid latency.
- Not defined: no LFSR is instantiated; both stalls are tied to 0; latency is a fixed 1 cycle.

Decomposition:
- Package obi_resp_pkg holds:
  - typedef obi_resp_t {logic [DATA_WIDTH-1:0] rdata; logic we;}
  - localparams for the byte-enable width and word-index width
  - the LFSR polynomial constant
- One natural sub-module: obi_resp_fifo, a parameterized in-order FIFO with depth, count, full/empty and simultaneous push/pop.
- The memory array and grant logic stay in the top module.

Test Plan:
- Write addr 0x10, be=4'b1111, wdata=0xDEADBEEF, then read 0x10 -> gnt same cycle as req; rvalid exactly 1 cycle after each grant; second rdata=0xDEADBEEF.
- Partial write be=4'b0010 wdata=0x0000AB00 onto 0x11223344, then read -> rdata=0x1122AB44.
- Read addr 0x1000 with MEM_DEPTH=1024 -> wraps to word 0; returns word 0 contents.
- Hold req for 4 reads with the stall macro defined and LFSR_SEED=16'hACE1 -> outstanding_o never exceeds 2; gnt=0 whenever count=2; rdata order matches grant order.
- Two back-to-back grants then rst=1 for one cycle -> no rvalid after reset; outstanding_o=0 and rvalid=0 at the first post-reset edge; memory writes performed before reset persist on readback.
- Simultaneous push and pop with count=1 -> count stays 1; rvalid pulses on consecutive cycles with no gap.

Source files
------------

// File: rtl/obi_resp_pkg.sv
// Shared types and constants for the OBI data-memory responder.
// Macro OBI_RESP_RAND_STALL_EN enables LFSR-driven grant/response stalls.
package obi_resp_pkg;

  localparam int OBI_DW        = 32;
  localparam int OBI_BE_W      = OBI_DW / 8;
  localparam int OBI_MEM_DEPTH = 1024;
  localparam int OBI_IDX_W     = $clog2(OBI_MEM_DEPTH);

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] OBI_LFSR_POLY = 16'hB400;

  typedef struct packed {
    logic [OBI_DW-1:0] rdata;
    logic              we;
  } obi_resp_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^
      (s[0] ? OBI_LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response FIFO with simultaneous push/pop.
// Ports: clk, rst, push_i/data_i, pop_i/data_o, count_o, full_o, empty_o.
module obi_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = inc(wptr_q);
    if (do_pop)  rptr_d = inc(rptr_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_data_mem_responder.sv
// OBI data-port memory responder: grants, byte-enabled writes, in-order reads.
// Ports: clk, rst, data_req/gnt/addr/we/be/wdata, data_rvalid/rdata, outstanding_o.
// Macro OBI_RESP_RAND_STALL_EN adds LFSR grant/rvalid backpressure.
module obi_data_mem_responder
  import obi_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = OBI_DW,
  parameter int          MEM_DEPTH       = OBI_MEM_DEPTH,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [1:0]              outstanding_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  gnt_stall, rvalid_stall;
  logic                  accept, pop;
  logic                  full, empty;
  logic [CW-1:0]         count;
  obi_resp_t             push_d, head;

  // Upper address bits wrap, low two bits are covered by byte enables
  assign idx = data_addr_i[IDX_W+1:2];

`ifdef OBI_RESP_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d       = lfsr_next(lfsr_q);
  assign gnt_stall    = lfsr_q[0] & lfsr_q[3];
  assign rvalid_stall = lfsr_q[5] & lfsr_q[9];

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign gnt_stall    = 1'b0;
  assign rvalid_stall = 1'b0;
`endif

  // Only the registered count gates the grant; a same-cycle pop does not help
  assign data_gnt_o = data_req_i && !full && !gnt_stall && !rst;
  assign accept     = data_req_i && data_gnt_o;

  always_comb begin
    push_d       = '0;
    push_d.we    = data_we_i;
    push_d.rdata = data_we_i ? '0 : mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (accept && data_we_i) begin
      for (int k = 0; k < BE_W; k++) begin
        if (data_be_i[k])
          mem_q[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  obi_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(obi_resp_t)),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (push_d),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head entry is presented and retired in the same cycle
  assign pop           = !empty && !rvalid_stall && !rst;
  assign data_rvalid_o = pop;
  assign data_rdata_o  = pop ? head.rdata : '0;

  // The presented entry is still counted until the edge that retires it
  assign outstanding_o = (count >= CW'(MAX_OUTSTANDING)) ?
                         2'(MAX_OUTSTANDING) : 2'(count);

  logic unused_ok;
  assign unused_ok = ^{data_addr_i[ADDR_WIDTH-1:IDX_W+2],
                       data_addr_i[1:0], head.we, LFSR_SEED};

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Self-checking bench for obi_data_mem_responder.
// Exact-timing table applies to the default build (no stall macro).
module tb_obi_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [1:0]  outst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm [1024];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  obi_data_mem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (req),
    .data_gnt_o    (gnt),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .outstanding_o (outst)
  );

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          egnt;
    bit          ervalid;
    logic [31:0] erdata;
    logic [1:0]  eout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  // One clock cycle: drive, sample, check against model, advance model
  task automatic cyc(input bit r, input bit q, input bit w,
                     input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output bit acc,
                     output bit s_gnt, output bit s_rv,
                     output logic [31:0] s_rd, output logic [1:0] s_out);
    int sz;
    @(negedge clk);
    rst = r; req = q; we = w; addr = a; be = b; wdata = d;
    #2;
    sz    = exp_q.size();
    s_gnt = gnt; s_rv = rvalid; s_rd = rdata; s_out = outst;
    chk("outstanding", {30'd0, outst}, (sz > 2) ? 32'd2 : 32'(sz));
`ifdef OBI_RESP_RAND_STALL_EN
    if (gnt) chk("gnt_legal", {31'd0, q && sz < 2 && !r}, 32'd1);
    if (rvalid) chk("rvalid_legal", {31'd0, sz > 0 && !r}, 32'd1);
`else
    chk("gnt", {31'd0, gnt}, {31'd0, q && sz < 2 && !r});
    chk("rvalid", {31'd0, rvalid}, {31'd0, sz > 0 && !r});
`endif
    if (rvalid && sz > 0) chk("rdata", rdata, exp_q[0]);
    acc = q && gnt;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (s_rv && sz > 0) void'(exp_q.pop_front());
      if (acc) begin
        if (w) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) mm[widx(a)][8*k +: 8] = d[8*k +: 8];
          exp_q.push_back(32'd0);
        end else begin
          exp_q.push_back(mm[widx(a)]);
        end
      end
    end
  endtask

  task automatic do_xfer(input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    bit acc, g, v;
    logic [31:0] rd;
    logic [1:0] o;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++)
      cyc(1'b0, 1'b1, w, a, b, d, acc, g, v, rd, o);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL grant_timeout: got none expected grant addr %h", a);
    end
  endtask

  task automatic drain();
    bit acc, g, v;
    logic [31:0] rd;
    logic [1:0] o;
    for (int k = 0; k < 64 && exp_q.size() != 0; k++)
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, acc, g, v, rd, o);
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
  endtask

  function automatic vec_t mk(bit q, bit w, logic [31:0] a, logic [3:0] b,
                              logic [31:0] d, bit eg, bit ev,
                              logic [31:0] er, logic [1:0] eo);
    vec_t t;
    t.req = q; t.we = w; t.addr = a; t.be = b; t.wdata = d;
    t.egnt = eg; t.ervalid = ev; t.erdata = er; t.eout = eo;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [12];
    bit          acc, g, v;
    logic [31:0] rd;
    logic [1:0]  o;

    tbl[0]  = mk(0, 0, 32'h0,    4'hF, 32'h0,        0, 0, 32'h0,        0);
    tbl[1]  = mk(1, 1, 32'h10,   4'hF, 32'hDEADBEEF, 1, 0, 32'h0,        0);
    tbl[2]  = mk(1, 0, 32'h10,   4'hF, 32'h0,        1, 1, 32'h0,        1);
    tbl[3]  = mk(0, 0, 32'h0,    4'h0, 32'h0,        0, 1, 32'hDEADBEEF, 1);
    tbl[4]  = mk(1, 1, 32'h20,   4'hF, 32'h11223344, 1, 0, 32'h0,        0);
    tbl[5]  = mk(1, 1, 32'h20,   4'h2, 32'h0000AB00, 1, 1, 32'h0,        1);
    tbl[6]  = mk(1, 0, 32'h20,   4'hF, 32'h0,        1, 1, 32'h0,        1);
    tbl[7]  = mk(1, 1, 32'h0,    4'hF, 32'hCAFEF00D, 1, 1, 32'h1122AB44, 1);
    tbl[8]  = mk(1, 0, 32'h1000, 4'hF, 32'h0,        1, 1, 32'h0,        1);
    tbl[9]  = mk(1, 0, 32'h1003, 4'h1, 32'h0,        1, 1, 32'hCAFEF00D, 1);
    tbl[10] = mk(0, 0, 32'h0,    4'h0, 32'h0,        0, 1, 32'hCAFEF00D, 1);
    tbl[11] = mk(0, 0, 32'h0,    4'h0, 32'h0,        0, 0, 32'h0,        0);

    rst = 1'b1; req = 1'b0; we = 1'b0;
    addr = '0; be = '0; wdata = '0;
    @(posedge clk);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, acc, g, v, rd, o);
    chk("reset_gnt", {31'd0, g}, 32'd0);
    chk("reset_rvalid", {31'd0, v}, 32'd0);

`ifdef OBI_RESP_RAND_STALL_EN
    do_xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    do_xfer(1'b1, 32'h20, 4'hF, 32'h11223344);
    do_xfer(1'b1, 32'h20, 4'h2, 32'h0000AB00);
    do_xfer(1'b0, 32'h20, 4'hF, 32'h0);
    do_xfer(1'b1, 32'h0,  4'hF, 32'hCAFEF00D);
    do_xfer(1'b0, 32'h1000, 4'hF, 32'h0);
    drain();
`else
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be,
          tbl[i].wdata, acc, g, v, rd, o);
      chk($sformatf("tbl%0d_gnt", i), {31'd0, g}, {31'd0, tbl[i].egnt});
      chk($sformatf("tbl%0d_rvalid", i), {31'd0, v},
          {31'd0, tbl[i].ervalid});
      chk($sformatf("tbl%0d_out", i), {30'd0, o}, {30'd0, tbl[i].eout});
      if (tbl[i].ervalid)
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].erdata);
    end
`endif

    // Reset with two responses in flight
    do_xfer(1'b0, 32'h10, 4'hF, 32'h0);
    do_xfer(1'b0, 32'h20, 4'hF, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, acc, g, v, rd, o);
    chk("rst_cycle_gnt", {31'd0, g}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc, g, v, rd, o);
    chk("post_rst_rvalid", {31'd0, v}, 32'd0);
    chk("post_rst_out", {30'd0, o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc, g, v, rd, o);
      chk("post_rst_quiet", {31'd0, v}, 32'd0);
    end
    do_xfer(1'b0, 32'h10, 4'hF, 32'h0);
    for (int k = 0; k < 64 && !v; k++)
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, acc, g, v, rd, o);
    chk("persist_rdata", rd, 32'hDEADBEEF);
    drain();

    // Random traffic over words 0..15 with aliased upper address bits
    for (int i = 0; i < 16; i++)
      do_xfer(1'b1, 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, ($urandom % 4) != 0, $urandom % 2,
          $urandom & 32'hFFFF_F03F, 4'($urandom), $urandom,
          acc, g, v, rd, o);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
